// File: rtl/i2c_slave_rx_if.sv
// i2c_slave_rx bus bundle: SCL input plus the register-write outputs.
// SDA stays a plain inout port on the responder so tristate resolution is portable.
interface i2c_slave_rx_if;
    logic       I2C_SCLK;
    logic [7:0] REG_ADDR;
    logic [7:0] REG_DATA;
    logic       WR_STROBE;
    logic       BUSY;
    logic       ERR;

    modport slave (
        input  I2C_SCLK,
        output REG_ADDR,
        output REG_DATA,
        output WR_STROBE,
        output BUSY,
        output ERR
    );

    modport master (
        output I2C_SCLK,
        input  REG_ADDR,
        input  REG_DATA,
        input  WR_STROBE,
        input  BUSY,
        input  ERR
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: oversampled I2C write-frame decoder (dev addr, reg addr, reg data).
// Optional I2C_SLAVE_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_slave_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic           CLK,
    input  logic           RST_L,
    i2c_slave_rx_if.slave  bus,
    inout  wire            I2C_SDAT
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, DATA, ACK_DATA, IGNORE
    } state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] sub_byte;
    logic       sda_oe;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_f;
    logic       sda_f;
    logic       scl_q;
    logic       sda_q;
    logic       sda_raw;
    logic       abort_err;

    // Open-drain: only ever pull low or release.
    assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

    // Our own ACK drive is masked so it never looks like master data.
    assign sda_raw = I2C_SDAT | sda_oe;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], bus.I2C_SCLK};
            sda_sync <= {sda_sync[0], sda_raw};
        end
    end

`ifdef I2C_SLAVE_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    // Sample history for the majority vote.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end

    assign scl_f = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1])
                 | (scl_hist[0] & scl_hist[1]);
    assign sda_f = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1])
                 | (sda_hist[0] & sda_hist[1]);
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    // Previous filtered levels for edge detection.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    wire scl_rise  = scl_f & ~scl_q;
    wire scl_fall  = ~scl_f & scl_q;
    wire start_det = scl_f & scl_q & sda_q & ~sda_f;
    wire stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    // A START/STOP here truncates a frame that had already begun.
    always_comb begin
        abort_err = 1'b0;
        case (state)
            ADDR:                abort_err = (bit_cnt != 4'd0);
            SUB, ACK_SUB, DATA:  abort_err = 1'b1;
            default:             abort_err = 1'b0;
        endcase
    end

    // Frame FSM with registered outputs; STOP outranks START.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state         <= IDLE;
            bit_cnt       <= 4'd0;
            shreg         <= 8'h00;
            sub_byte      <= 8'h00;
            sda_oe        <= 1'b0;
            bus.REG_ADDR  <= 8'h00;
            bus.REG_DATA  <= 8'h00;
            bus.WR_STROBE <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.ERR       <= 1'b0;
        end else begin
            bus.WR_STROBE <= 1'b0;
            bus.ERR       <= 1'b0;
            if (stop_det) begin
                state    <= IDLE;
                bit_cnt  <= 4'd0;
                sda_oe   <= 1'b0;
                bus.BUSY <= 1'b0;
                bus.ERR  <= abort_err;
            end else if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= 4'd0;
                sda_oe   <= 1'b0;
                bus.BUSY <= 1'b1;
                bus.ERR  <= abort_err;
            end else begin
                case (state)
                    ADDR, SUB, DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                                    state  <= ACK_ADDR;
                                    sda_oe <= 1'b1;
                                end else begin
                                    state  <= IGNORE;
                                end
                            end else if (state == SUB) begin
                                sub_byte <= shreg;
                                state    <= ACK_SUB;
                                sda_oe   <= 1'b1;
                            end else begin
                                bus.REG_ADDR  <= sub_byte;
                                bus.REG_DATA  <= shreg;
                                bus.WR_STROBE <= 1'b1;
                                state         <= ACK_DATA;
                                sda_oe        <= 1'b1;
                            end
                        end
                    end
                    ACK_ADDR: if (scl_fall) begin
                        state  <= SUB;
                        sda_oe <= 1'b0;
                    end
                    ACK_SUB: if (scl_fall) begin
                        state  <= DATA;
                        sda_oe <= 1'b0;
                    end
                    ACK_DATA: if (scl_fall) begin
                        state  <= IGNORE;
                        sda_oe <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
